// File: rtl/npc_pkg.sv
// Shared definitions for the NPC dead-time stage.
//   - NPC_P/NPC_O/NPC_N : raw leg commands from the modulator (bit3..0 = S1..S4)
//   - leg_st_e          : per-leg sequencer state
//   - GATE_*            : registered gate pattern driven in each state
//   - cmd_valid/cmd2st/gate_of : decode helpers shared by the leg FSM
package npc_pkg;

  localparam logic [3:0] NPC_P = 4'b1100;
  localparam logic [3:0] NPC_O = 4'b0110;
  localparam logic [3:0] NPC_N = 4'b0011;

  typedef enum logic [2:0] {
    ST_OFF = 3'd0,
    ST_P   = 3'd1,
    ST_DH  = 3'd2,   // dead step between P and O
    ST_O   = 3'd3,
    ST_DL  = 3'd4,   // dead step between O and N
    ST_N   = 3'd5
  } leg_st_e;

  localparam logic [3:0] GATE_OFF = 4'b0000;
  localparam logic [3:0] GATE_P   = 4'b1100;
  localparam logic [3:0] GATE_DH  = 4'b0100;
  localparam logic [3:0] GATE_O   = 4'b0110;
  localparam logic [3:0] GATE_DL  = 4'b0010;
  localparam logic [3:0] GATE_N   = 4'b0011;

  function automatic logic cmd_valid(input logic [3:0] c);
    return (c == NPC_P) || (c == NPC_O) || (c == NPC_N);
  endfunction

  // Only meaningful when cmd_valid(c); anything else maps to O.
  function automatic leg_st_e cmd2st(input logic [3:0] c);
    case (c)
      NPC_P:   return ST_P;
      NPC_N:   return ST_N;
      default: return ST_O;
    endcase
  endfunction

  function automatic logic [3:0] gate_of(input leg_st_e s);
    case (s)
      ST_P:    return GATE_P;
      ST_DH:   return GATE_DH;
      ST_O:    return GATE_O;
      ST_DL:   return GATE_DL;
      ST_N:    return GATE_N;
      default: return GATE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/npc_dt_leg.sv
// One NPC leg: level sequencer with dead-time counter.
//   clk, rst      : clock, async active-high reset
//   ce            : enable; low forces OFF on the next edge
//   cmd[3:0]      : raw command (S1..S4)
//   gate[3:0]     : registered shoot-through-safe gates
//   dt_active     : leg in DH/DL, or waiting in OFF with ce high
//   fault         : sticky invalid-command flag (only with NPC_DT_FAULT_EN,
//                   otherwise tied 0 and invalid commands are ignored)
module npc_dt_leg
  import npc_pkg::*;
#(
  parameter int DT_CYCLES = 50,
  parameter int DT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [3:0] cmd,
  output logic [3:0] gate,
  output logic       dt_active,
  output logic       fault
);

  localparam logic [DT_W-1:0] DT_LD = DT_W'(DT_CYCLES - 1);

  leg_st_e         st_q, st_nxt;
  logic [DT_W-1:0] cnt_q, cnt_nxt;
  logic            arm_q, arm_nxt;     // OFF-wait countdown in progress
  leg_st_e         last_q;             // last valid commanded level
  logic            have_q;             // a valid command has been seen
  logic            cmd_vld;
  leg_st_e         tgt;
  logic            tgt_ok;

  // Invalid commands fall back to the last valid target.
  assign cmd_vld = cmd_valid(cmd);
  assign tgt     = cmd_vld ? cmd2st(cmd) : last_q;
  assign tgt_ok  = cmd_vld | have_q;

`ifdef NPC_DT_FAULT_EN
  logic flt_q, flt_nxt;
  assign fault = flt_q;
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    st_nxt  = st_q;
    cnt_nxt = cnt_q;
    arm_nxt = arm_q;
`ifdef NPC_DT_FAULT_EN
    flt_nxt = flt_q;
`endif
    if (!ce) begin
      st_nxt  = ST_OFF;
      cnt_nxt = '0;
      arm_nxt = 1'b0;
    end else begin
      case (st_q)
        ST_OFF: begin
          if (!arm_q) begin
            if (tgt_ok) begin
              arm_nxt = 1'b1;
              cnt_nxt = DT_LD;
            end
          end else if (cnt_q != '0) begin
            cnt_nxt = cnt_q - DT_W'(1);
          end else begin
            // Level sampled at expiry is entered directly.
            st_nxt  = tgt;
            arm_nxt = 1'b0;
          end
        end
        ST_P, ST_O, ST_N: begin
          if (tgt != st_q) begin
            cnt_nxt = DT_LD;
            if (st_q == ST_P)      st_nxt = ST_DH;
            else if (st_q == ST_N) st_nxt = ST_DL;
            else                   st_nxt = (tgt == ST_P) ? ST_DH : ST_DL;
          end
        end
        ST_DH: begin
          if (cnt_q != '0) cnt_nxt = cnt_q - DT_W'(1);
          else             st_nxt  = (tgt == ST_P) ? ST_P : ST_O;
        end
        ST_DL: begin
          if (cnt_q != '0) cnt_nxt = cnt_q - DT_W'(1);
          else             st_nxt  = (tgt == ST_N) ? ST_N : ST_O;
        end
        default: begin
          st_nxt  = ST_OFF;
          cnt_nxt = '0;
          arm_nxt = 1'b0;
        end
      endcase
    end
`ifdef NPC_DT_FAULT_EN
    // Latched fault parks the leg in OFF regardless of ce until reset.
    if (flt_q || (ce && !cmd_vld)) begin
      flt_nxt = 1'b1;
      st_nxt  = ST_OFF;
      cnt_nxt = '0;
      arm_nxt = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_OFF;
      cnt_q  <= '0;
      arm_q  <= 1'b0;
      last_q <= ST_O;
      have_q <= 1'b0;
      gate   <= GATE_OFF;
`ifdef NPC_DT_FAULT_EN
      flt_q  <= 1'b0;
`endif
    end else begin
      st_q  <= st_nxt;
      cnt_q <= cnt_nxt;
      arm_q <= arm_nxt;
      gate  <= gate_of(st_nxt);
      if (cmd_vld) begin
        last_q <= cmd2st(cmd);
        have_q <= 1'b1;
      end
`ifdef NPC_DT_FAULT_EN
      flt_q <= flt_nxt;
`endif
    end
  end

  assign dt_active = (st_q == ST_DH) || (st_q == ST_DL) ||
                     ((st_q == ST_OFF) && ce && !fault);

endmodule

// File: rtl/npc_deadtime.sv
// Dead-time insertion for a three-level NPC bridge (three independent legs).
//   clk, rst                  : clock, async active-high reset
//   ce                        : output enable (low -> all gates off)
//   NPC_outa/b/c[3:0]         : raw leg commands from DCMG, bit3..0 = S1..S4
//   gate_a/b/c[3:0]           : dead-time-safe gates, bit3..0 = S1..S4
//   dt_active[2:0]            : {c,b,a} leg in dead or OFF-wait state
//   fault[2:0]                : {c,b,a} sticky invalid-command flag
// Optional: define NPC_DT_FAULT_EN to latch invalid commands as faults.
module npc_deadtime #(
  parameter int DT_CYCLES = 50,
  parameter int DT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [3:0] NPC_outa,
  input  logic [3:0] NPC_outb,
  input  logic [3:0] NPC_outc,
  output logic [3:0] gate_a,
  output logic [3:0] gate_b,
  output logic [3:0] gate_c,
  output logic [2:0] dt_active,
  output logic [2:0] fault
);

  localparam int NUM_LEGS = 3;

  logic [NUM_LEGS-1:0][3:0] cmd_v;
  logic [NUM_LEGS-1:0][3:0] gate_v;

  assign cmd_v = {NPC_outc, NPC_outb, NPC_outa};

  for (genvar i = 0; i < NUM_LEGS; i++) begin : g_leg
    npc_dt_leg #(
      .DT_CYCLES (DT_CYCLES),
      .DT_W      (DT_W)
    ) u_leg (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .cmd       (cmd_v[i]),
      .gate      (gate_v[i]),
      .dt_active (dt_active[i]),
      .fault     (fault[i])
    );
  end

  assign gate_a = gate_v[0];
  assign gate_b = gate_v[1];
  assign gate_c = gate_v[2];

endmodule
